// File: rtl/bsg_piso_pkg.sv
// Shared types and helpers for the chunked parallel-in/serial-out converter.
package bsg_piso_pkg;

    // Transmitter state: idle (no active word) or transmitting beats.
    typedef enum logic {
        eIDLE = 1'b0,
        eTX   = 1'b1
    } state_e;

    // Integer max, used to keep counter widths at least one bit.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_piso_slot.sv
// One-entry holding register with a valid bit; the data half is not reset.
module bsg_piso_slot
    import bsg_piso_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [width_p-1:0] wdata,
    output logic [width_p-1:0] rdata,
    output logic               valid
);

    logic [width_p-1:0] data_r;

    // Valid bit: load wins over clear, although the owner never asserts both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload capture; contents are meaningless while valid is low.
    always_ff @(posedge clk) begin
        if (load) begin
            data_r <= wdata;
        end
    end

    assign rdata = data_r;

endmodule

// File: rtl/bsg_piso_chunked.sv
// Chunked PISO: accepts a width_p word plus a beat count and emits it as
// chunk_p-wide beats, LSB- or MSB-chunk first. One pending slot lets the next
// word be accepted while the current one is still being sent, so words
// stream without bubbles when the consumer never stalls.
//
// Handshakes: the input side is valid-then-yumi (yumi_o only ever rises when
// valid_i is already high and never looks at yumi_i); the output side is
// valid/yumi, where yumi_i may only be high while valid_o is high and means
// the current beat is consumed on this clock edge.
module bsg_piso_chunked
    import bsg_piso_pkg::*;
#(
    parameter width_p     = "inv",
    parameter chunk_p     = 1,
    parameter msb_first_p = 0,
    localparam int els_lp    = width_p / chunk_p,
    localparam int lg_els_lp = max_int(1, $clog2(els_lp))
) (
    input  logic                 clk_i,
    input  logic                 reset_i,

    input  logic                 valid_i,
    output logic                 yumi_o,
    input  logic [width_p-1:0]   data_i,
    input  logic [lg_els_lp-1:0] len_i,

    output logic                 valid_o,
    input  logic                 yumi_i,
    output logic [chunk_p-1:0]   data_o,
    output logic                 last_o,

    output logic                 state_o
);

    localparam logic [lg_els_lp-1:0] max_len_lp = lg_els_lp'(els_lp - 1);

    state_e                 state_r;
    logic [lg_els_lp-1:0]   ctr_r;
    logic [lg_els_lp-1:0]   len_r;
    logic [width_p-1:0]     data_r;

    logic                   pend_v;
    logic [width_p-1:0]     pend_data;
    logic [lg_els_lp-1:0]   pend_len;

    logic [lg_els_lp-1:0]   len_clamped;
    logic                   at_last;
    logic                   done;
    logic                   idle_load;
    logic                   direct_load;
    logic                   promote;
    logic                   pend_load;
    logic [lg_els_lp-1:0]   sel;
    logic [31:0]            sel_bit;

    // Accept whenever the pending slot is free; reset masks it immediately.
    assign yumi_o = valid_i & ~pend_v & ~reset_i;

    // Next-word bookkeeping: which source feeds the active register and when
    // the pending slot fills or drains.
    always_comb begin
        len_clamped = (len_i > max_len_lp) ? max_len_lp : len_i;
        at_last     = (ctr_r == len_r);
        done        = (state_r == eTX) & at_last & yumi_i;
        idle_load   = (state_r == eIDLE) & yumi_o;
        direct_load = done & ~pend_v & yumi_o;
        promote     = done & pend_v;
        pend_load   = (state_r == eTX) & ~done & yumi_o;
    end

    bsg_piso_slot #(
        .width_p (width_p + lg_els_lp)
    ) slot (
        .clk   (clk_i),
        .reset (reset_i),
        .load  (pend_load),
        .clear (promote),
        .wdata ({len_clamped, data_i}),
        .rdata ({pend_len, pend_data}),
        .valid (pend_v)
    );

    // Active word payload: from the pending slot on promotion, else from the input.
    always_ff @(posedge clk_i) begin
        if (promote) begin
            data_r <= pend_data;
            len_r  <= pend_len;
        end else if (idle_load | direct_load) begin
            data_r <= data_i;
            len_r  <= len_clamped;
        end
    end

    // Control FSM: state and beat counter; every new word starts at beat 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            ctr_r   <= '0;
        end else begin
            case (state_r)
                eIDLE: begin
                    if (yumi_o) begin
                        state_r <= eTX;
                        ctr_r   <= '0;
                    end
                end
                eTX: begin
                    if (done) begin
                        ctr_r <= '0;
                        if (!pend_v && !yumi_o) begin
                            state_r <= eIDLE;
                        end
                    end else if (yumi_i) begin
                        ctr_r <= ctr_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= eIDLE;
                    ctr_r   <= '0;
                end
            endcase
        end
    end

    // Beat selection: MSB-first counts down from the word's last chunk.
    always_comb begin
        if (msb_first_p != 0) begin
            sel = len_r - ctr_r;
        end else begin
            sel = ctr_r;
        end
        sel_bit = 32'(sel) * 32'(chunk_p);
    end

    assign data_o  = data_r[sel_bit +: chunk_p];
    assign valid_o = (state_r == eTX);
    assign last_o  = valid_o & at_last;
    assign state_o = state_r;

endmodule

// File: tb/tb_bsg_piso_chunked.sv
// Directed bench for bsg_piso_chunked: LSB/MSB order, streaming, stalls,
// short words, length clamping and asynchronous reset.
module tb_bsg_piso_chunked;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // 16-bit, 4-bit chunks, LSB first
    logic        a_valid_i = 1'b0, a_yumi_i = 1'b0;
    logic [15:0] a_data_i  = '0;
    logic [1:0]  a_len_i   = '0;
    logic        a_yumi_o, a_valid_o, a_last_o, a_state_o;
    logic [3:0]  a_data_o;

    // 16-bit, 4-bit chunks, MSB first
    logic        m_valid_i = 1'b0, m_yumi_i = 1'b0;
    logic [15:0] m_data_i  = '0;
    logic [1:0]  m_len_i   = '0;
    logic        m_yumi_o, m_valid_o, m_last_o, m_state_o;
    logic [3:0]  m_data_o;

    // 12-bit, 4-bit chunks (three beats max), LSB first
    logic        s_valid_i = 1'b0, s_yumi_i = 1'b0;
    logic [11:0] s_data_i  = '0;
    logic [1:0]  s_len_i   = '0;
    logic        s_yumi_o, s_valid_o, s_last_o, s_state_o;
    logic [3:0]  s_data_o;

    bsg_piso_chunked #(.width_p(16), .chunk_p(4), .msb_first_p(0)) dut (
        .clk_i(clk), .reset_i(rst),
        .valid_i(a_valid_i), .yumi_o(a_yumi_o), .data_i(a_data_i), .len_i(a_len_i),
        .valid_o(a_valid_o), .yumi_i(a_yumi_i), .data_o(a_data_o), .last_o(a_last_o),
        .state_o(a_state_o)
    );

    bsg_piso_chunked #(.width_p(16), .chunk_p(4), .msb_first_p(1)) dut_msb (
        .clk_i(clk), .reset_i(rst),
        .valid_i(m_valid_i), .yumi_o(m_yumi_o), .data_i(m_data_i), .len_i(m_len_i),
        .valid_o(m_valid_o), .yumi_i(m_yumi_i), .data_o(m_data_o), .last_o(m_last_o),
        .state_o(m_state_o)
    );

    bsg_piso_chunked #(.width_p(12), .chunk_p(4), .msb_first_p(0)) dut_12 (
        .clk_i(clk), .reset_i(rst),
        .valid_i(s_valid_i), .yumi_o(s_yumi_o), .data_i(s_data_i), .len_i(s_len_i),
        .valid_o(s_valid_o), .yumi_i(s_yumi_i), .data_o(s_data_o), .last_o(s_last_o),
        .state_o(s_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic test_reset();
        a_valid_i = 1'b1;
        a_data_i  = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({a_valid_o, a_last_o, a_yumi_o, a_state_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_a: valid/last/yumi/state=%b required=0000",
                     {a_valid_o, a_last_o, a_yumi_o, a_state_o});
        end
        vectors++;
        if ({m_valid_o, m_last_o, m_yumi_o, s_valid_o, s_last_o, s_yumi_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ms: outputs=%b required=000000",
                     {m_valid_o, m_last_o, m_yumi_o, s_valid_o, s_last_o, s_yumi_o});
        end
        @(negedge clk);
        rst       = 1'b0;
        a_valid_i = 1'b0;
        #1;
        vectors++;
        if (a_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: valid_o=%b required=0", a_valid_o);
        end
    endtask

    task automatic test_lsb_first();
        logic [15:0] exp_beats = 16'hA5C3;
        @(negedge clk);
        a_valid_i = 1'b1; a_data_i = 16'hA5C3; a_len_i = 2'd3; a_yumi_i = 1'b1;
        #1;
        vectors++;
        if (a_yumi_o !== 1'b1 || a_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_accept: yumi_o=%b valid_o=%b required 1 0", a_yumi_o, a_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid_i = 1'b0;
            #1;
            vectors++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp_beats[i*4 +: 4] || a_last_o !== (i == 3)) begin
                miscompares++;
                $display("FAIL lsb_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                         i, a_valid_o, a_data_o, a_last_o, exp_beats[i*4 +: 4], (i == 3));
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (a_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_end: valid_o=%b required=0", a_valid_o);
        end
    endtask

    task automatic test_msb_first();
        logic [15:0] exp_beats = 16'h3C5A;
        @(negedge clk);
        m_valid_i = 1'b1; m_data_i = 16'hA5C3; m_len_i = 2'd3; m_yumi_i = 1'b1;
        #1;
        vectors++;
        if (m_yumi_o !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_accept: yumi_o=%b required=1", m_yumi_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_valid_i = 1'b0;
            #1;
            vectors++;
            if (m_valid_o !== 1'b1 || m_data_o !== exp_beats[i*4 +: 4] || m_last_o !== (i == 3)) begin
                miscompares++;
                $display("FAIL msb_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                         i, m_valid_o, m_data_o, m_last_o, exp_beats[i*4 +: 4], (i == 3));
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_end: valid_o=%b required=0", m_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_beats = 32'hABCD1234;
        @(negedge clk);
        a_valid_i = 1'b1; a_data_i = 16'h1234; a_len_i = 2'd3; a_yumi_i = 1'b1;
        #1;
        vectors++;
        if (a_yumi_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept0: yumi_o=%b required=1", a_yumi_o);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a_valid_i = 1'b1; a_data_i = 16'hABCD; a_len_i = 2'd3;
            end else begin
                a_valid_i = 1'b0;
            end
            #1;
            if (i == 0) begin
                vectors++;
                if (a_yumi_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_accept1: yumi_o=%b required=1", a_yumi_o);
                end
            end
            vectors++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp_beats[i*4 +: 4] ||
                a_last_o !== (i == 3 || i == 7)) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                         i, a_valid_o, a_data_o, a_last_o, exp_beats[i*4 +: 4], (i == 3 || i == 7));
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (a_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: valid_o=%b required=0", a_valid_o);
        end
    endtask

    task automatic test_stall();
        logic [23:0] exp_data  = 24'hA5CCC3;
        logic [5:0]  yumi_pat  = 6'b111001;
        logic [5:0]  last_mask = 6'b100000;
        @(negedge clk);
        a_valid_i = 1'b1; a_data_i = 16'hA5C3; a_len_i = 2'd3; a_yumi_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_valid_i = 1'b0;
            a_yumi_i  = yumi_pat[i];
            #1;
            vectors++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp_data[i*4 +: 4] || a_last_o !== last_mask[i]) begin
                miscompares++;
                $display("FAIL stall_cyc%0d: valid=%b data=%h last=%b required 1 %h %b",
                         i, a_valid_o, a_data_o, a_last_o, exp_data[i*4 +: 4], last_mask[i]);
            end
        end
        @(negedge clk);
        a_yumi_i = 1'b1;
        #1;
        vectors++;
        if (a_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_end: valid_o=%b required=0", a_valid_o);
        end
    endtask

    task automatic test_short_len();
        logic [7:0] exp_beats = 8'hF7;
        @(negedge clk);
        a_valid_i = 1'b1; a_data_i = 16'h00F7; a_len_i = 2'd1; a_yumi_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_valid_i = 1'b0;
            #1;
            vectors++;
            if (i < 2) begin
                if (a_valid_o !== 1'b1 || a_data_o !== exp_beats[i*4 +: 4] || a_last_o !== (i == 1)) begin
                    miscompares++;
                    $display("FAIL short_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                             i, a_valid_o, a_data_o, a_last_o, exp_beats[i*4 +: 4], (i == 1));
                end
            end else if (a_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL short_end: valid_o=%b required=0", a_valid_o);
            end
        end
    endtask

    task automatic test_clamp();
        logic [11:0] exp_beats = 12'h9E2;
        @(negedge clk);
        s_valid_i = 1'b1; s_data_i = 12'h9E2; s_len_i = 2'd3; s_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid_i = 1'b0;
            #1;
            vectors++;
            if (i < 3) begin
                if (s_valid_o !== 1'b1 || s_data_o !== exp_beats[i*4 +: 4] || s_last_o !== (i == 2)) begin
                    miscompares++;
                    $display("FAIL clamp_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                             i, s_valid_o, s_data_o, s_last_o, exp_beats[i*4 +: 4], (i == 2));
                end
            end else if (s_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL clamp_end: valid_o=%b required=0", s_valid_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_beats = 16'h5678;
        @(negedge clk);
        a_valid_i = 1'b1; a_data_i = 16'h1234; a_len_i = 2'd3; a_yumi_i = 1'b1;
        @(negedge clk);
        a_data_i = 16'hABCD;
        @(negedge clk);
        a_valid_i = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (a_valid_o !== 1'b1 || a_data_o !== 4'h2) begin
            miscompares++;
            $display("FAIL rstmid_pre: valid=%b data=%h required 1 2", a_valid_o, a_data_o);
        end
        a_valid_i = 1'b1; a_data_i = 16'h5678; a_len_i = 2'd3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({a_valid_o, a_last_o, a_yumi_o, a_state_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_async: valid/last/yumi/state=%b required=0000",
                     {a_valid_o, a_last_o, a_yumi_o, a_state_o});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (a_yumi_o !== 1'b1 || a_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_accept: yumi_o=%b valid_o=%b required 1 0", a_yumi_o, a_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_valid_i = 1'b0;
            #1;
            vectors++;
            if (i < 4) begin
                if (a_valid_o !== 1'b1 || a_data_o !== exp_beats[i*4 +: 4] || a_last_o !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL rstmid_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                             i, a_valid_o, a_data_o, a_last_o, exp_beats[i*4 +: 4], (i == 3));
                end
            end else if (a_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_end: valid_o=%b required=0 (stale word resurfaced)", a_valid_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_short_len();
        test_clamp();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bsg_piso_chunked.md
BSG_PISO_CHUNKED -- requirements
Module: bsg_piso_chunked

Interface
REQ-001 The module SHALL have parameter width_p, default "inv", giving the parallel input word width in bits.
REQ-002 The module SHALL have parameter chunk_p, default 1, giving the output beat width in bits; width_p SHALL be an integer multiple of chunk_p.
REQ-003 The module SHALL have parameter msb_first_p, default 0, where 0 selects LSB-chunk-first order and 1 selects MSB-chunk-first order.
REQ-004 The module SHALL define derived constants els_lp = width_p/chunk_p and lg_els_lp = max(1, $clog2(els_lp)).
REQ-005 clk_i  input  1  the single clock.
REQ-006 reset_i  input  1  reset, asynchronous and active-high.
REQ-007 valid_i  input  1  input word valid.
REQ-008 yumi_o  output  1  input word accepted this cycle.
REQ-009 data_i  input  width_p  parallel input word.
REQ-010 len_i  input  lg_els_lp  number of beats to send minus one, sampled with data_i.
REQ-011 valid_o  output  1  output beat valid.
REQ-012 yumi_i  input  1  output beat consumed this cycle.
REQ-013 data_o  output  chunk_p  current output beat.
REQ-014 last_o  output  1  current beat is the final beat of its word.

Function
REQ-015 The input channel SHALL use valid-then-yumi: yumi_o = valid_i & ~pending_v_r & ~reset_i, with no combinational dependence on yumi_i.
REQ-016 Storage SHALL consist of an active word (data, len, beat counter) and one pending slot (data, len, valid bit).
REQ-017 The state machine SHALL have states eIDLE and eTX; valid_o SHALL equal (state_r == eTX).
REQ-018 done SHALL equal eTX & (ctr_r == len_r) & yumi_i.
REQ-019 In eIDLE, an accepted word SHALL load the active register, clear ctr_r, and move to eTX on the next edge.
REQ-020 In eTX without done, an accepted word SHALL load the pending slot.
REQ-021 On done with the pending slot full, the pending word SHALL move to active, ctr_r SHALL clear, the slot SHALL empty, and the state SHALL stay eTX.
REQ-022 On done with the slot empty and yumi_o high, the incoming word SHALL load active directly and the state SHALL stay eTX.
REQ-023 On done with the slot empty and no accept, the state SHALL return to eIDLE.
REQ-024 In eTX, yumi_i high without done SHALL increment ctr_r by 1; yumi_i low SHALL hold ctr_r and data_o stable.
REQ-025 A sampled len_i greater than els_lp-1 SHALL be clamped to els_lp-1.
REQ-026 With msb_first_p=0, data_o SHALL equal chunk index ctr_r of the active word.
REQ-027 With msb_first_p=1, data_o SHALL equal chunk index (len_r - ctr_r) of the active word.
REQ-028 last_o SHALL equal valid_o & (ctr_r == len_r).
REQ-029 Back-to-back words SHALL stream with zero bubble cycles when yumi_i is held high.
REQ-030 data_o SHALL be don't-care while valid_o is low.

Reset
REQ-031 Asserting reset_i SHALL immediately force state eIDLE, pending_v_r=0, ctr_r=0, valid_o=0, last_o=0 and yumi_o=0, without waiting for a clock edge.
REQ-032 Reset mid-transmission SHALL discard the active and pending words; after deassertion, the first accepted word SHALL start at beat 0.
REQ-033 Data registers need not be reset.

Structure
REQ-034 Package bsg_piso_pkg SHALL hold the state_e enum {eIDLE, eTX}.
REQ-035 The pending slot SHALL be a sub-module, bsg_piso_slot: a width_p+lg_els_lp register with valid bit and async reset.
REQ-036 Chunk selection SHALL be an indexed part-select, with no additional sub-module.

Verification (width_p=16, chunk_p=4)
REQ-037 Word 0xA5C3, len_i=3, msb_first_p=0, yumi_i=1 -> beats 3,C,5,A with last_o on beat 4; yumi_o high in the accept cycle.
REQ-038 Same stimulus with msb_first_p=1 -> beats A,5,C,3.
REQ-039 Words 0x1234 and 0xABCD offered back-to-back, yumi_i=1 -> 8 contiguous beats 4,3,2,1,D,C,B,A; second yumi_o one cycle after the first; no bubble.
REQ-040 yumi_i pattern 1,0,0,1,1,1 on 0xA5C3 -> data_o holds C for three cycles and the sequence completes unchanged.
REQ-041 len_i=1 on 0x00F7 -> beats 7,F, last_o on beat 2; on a 12-bit build (els_lp=3), len_i=3 is clamped to 2 -> 3 beats.
REQ-042 Asynchronous reset after 2 beats with the pending slot full -> valid_o falls without a clock edge; after release, the next word starts at beat 0 and the old words never appear.
